// File: rtl/lemmings_array_splat.sv
// N independent lock-step Lemming FSMs (walk/fall/dig/splat) with a per-channel fall counter.
// Outputs are Moore decodes of registered state; alive_cnt is a combinational popcount of survivors.
module lemmings_array_splat #(
    parameter int N           = 4,
    parameter int SPLAT_LIMIT = 20,
    parameter int CNT_W       = 5,
    localparam int ACW        = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           areset,
    input  logic [N-1:0]   bump_left,
    input  logic [N-1:0]   bump_right,
    input  logic [N-1:0]   ground,
    input  logic [N-1:0]   dig,
    output logic [N-1:0]   walk_left,
    output logic [N-1:0]   walk_right,
    output logic [N-1:0]   aaah,
    output logic [N-1:0]   digging,
    output logic [N-1:0]   splat,
    output logic [ACW-1:0] alive_cnt
);

    generate
        if ((2 ** CNT_W) - 1 < SPLAT_LIMIT) begin : g_bad_cnt_w
            $error("CNT_W too narrow to hold SPLAT_LIMIT");
        end
    endgenerate

    localparam logic [2:0] ST_WL    = 3'd0;
    localparam logic [2:0] ST_WR    = 3'd1;
    localparam logic [2:0] ST_FALLL = 3'd2;
    localparam logic [2:0] ST_FALLR = 3'd3;
    localparam logic [2:0] ST_DIGL  = 3'd4;
    localparam logic [2:0] ST_DIGR  = 3'd5;
    localparam logic [2:0] ST_SPLAT = 3'd6;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(SPLAT_LIMIT);

    logic [2:0]       r_state      [N];
    logic [CNT_W-1:0] r_fall_cnt   [N];
    logic [2:0]       w_next_state [N];
    logic [CNT_W-1:0] w_next_cnt   [N];
    logic [ACW-1:0]   w_alive;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < N; i++) begin
                r_state[i]    <= ST_WL;
                r_fall_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                r_state[i]    <= w_next_state[i];
                r_fall_cnt[i] <= w_next_cnt[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_next_state[i] = ST_WL;
            w_next_cnt[i]   = '0;
            case (r_state[i])
                ST_WL: begin
                    if (!ground[i])         w_next_state[i] = ST_FALLL;
                    else if (dig[i])        w_next_state[i] = ST_DIGL;
                    else if (bump_left[i])  w_next_state[i] = ST_WR;
                    else                    w_next_state[i] = ST_WL;
                end
                ST_WR: begin
                    if (!ground[i])         w_next_state[i] = ST_FALLR;
                    else if (dig[i])        w_next_state[i] = ST_DIGR;
                    else if (bump_right[i]) w_next_state[i] = ST_WL;
                    else                    w_next_state[i] = ST_WR;
                end
                ST_DIGL: w_next_state[i] = ground[i] ? ST_DIGL : ST_FALLL;
                ST_DIGR: w_next_state[i] = ground[i] ? ST_DIGR : ST_FALLR;
                ST_FALLL, ST_FALLR: begin
                    // Counter holds completed fall cycles, so >= LIMIT means LIMIT+1 aaah cycles.
                    if (!ground[i])                      w_next_state[i] = r_state[i];
                    else if (r_fall_cnt[i] >= CNT_LIM)   w_next_state[i] = ST_SPLAT;
                    else if (r_state[i] == ST_FALLL)     w_next_state[i] = ST_WL;
                    else                                 w_next_state[i] = ST_WR;
                    w_next_cnt[i] = (r_fall_cnt[i] == CNT_MAX) ? CNT_MAX
                                                               : r_fall_cnt[i] + CNT_W'(1);
                end
                ST_SPLAT: w_next_state[i] = ST_SPLAT;
                default:  w_next_state[i] = ST_WL;
            endcase
        end
    end

    always_comb begin
        w_alive = ACW'(N);
        for (int i = 0; i < N; i++) begin
            walk_left[i]  = (r_state[i] == ST_WL);
            walk_right[i] = (r_state[i] == ST_WR);
            aaah[i]       = (r_state[i] == ST_FALLL) || (r_state[i] == ST_FALLR);
            digging[i]    = (r_state[i] == ST_DIGL) || (r_state[i] == ST_DIGR);
            splat[i]      = (r_state[i] == ST_SPLAT);
            if (r_state[i] == ST_SPLAT) w_alive = w_alive - ACW'(1);
        end
        alive_cnt = w_alive;
    end

endmodule

// File: doc/lemmings_array_splat.md
# lemmings_array_splat

Parametrised multi-channel Lemmings controller. It runs N independent Lemming state machines in lock-step on one clock. It extends the walk / fall / dig behaviour with a configurable fall-height splat rule and a population count. The block sits in the game-logic layer: per-lemming sensor bits come in and per-lemming action flags go out.

## Interface
Parameters:
- N, default 4: number of independent lemming channels (N ≥ 1).
- SPLAT_LIMIT, default 20: maximum number of fall cycles a lemming survives.
- CNT_W, default 5: width of each per-channel fall counter. Must satisfy 2^CNT_W − 1 ≥ SPLAT_LIMIT. Elaboration fails otherwise.
- Local ACW = $clog2(N+1): width of alive_cnt.

Ports:
- clk  in  1  clock, rising edge.
- areset  in  1  reset, asynchronous, active-high. Forces every channel to WL.
- bump_left  in  N  per-channel left obstacle.
- bump_right  in  N  per-channel right obstacle.
- ground  in  N  per-channel ground present.
- dig  in  N  per-channel dig request.
- walk_left  out  N  channel state is WL.
- walk_right  out  N  channel state is WR.
- aaah  out  N  channel state is FALLL or FALLR.
- digging  out  N  channel state is DIGL or DIGR.
- splat  out  N  channel state is SPLAT.
- alive_cnt  out  ACW  number of channels not in SPLAT.

## Operation
- Each channel i has private state and fall_cnt[i]. Channel i uses only input bits [i]. Channels never interact.
- Per-channel states: WL, WR, FALLL, FALLR, DIGL, DIGR, SPLAT.
- Transition priority in WL: !ground → FALLL; else dig → DIGL; else bump_left → WR; else WL.
- Transition priority in WR: !ground → FALLR; else dig → DIGR; else bump_right → WL; else WR.
- A bump while falling or digging is ignored. In walk states, bump_left and bump_right are each checked only for their own direction.
- DIGL: ground → DIGL; !ground → FALLL.
- DIGR: ground → DIGR; !ground → FALLR.
- FALLL / FALLR with !ground: stay in the same fall state.
- FALLL / FALLR with ground: if fall_cnt ≥ SPLAT_LIMIT → SPLAT; else → WL (from FALLL) or WR (from FALLR).
- SPLAT is absorbing. Only areset leaves it. All inputs are ignored.
- fall_cnt: cleared to 0 on any edge where the current state is not a fall state. Incremented by 1 on each edge where the current state is a fall state. Saturates at 2^CNT_W − 1 and never wraps.
- Meaning of fall_cnt: the number of completed aaah cycles before the current one. A lemming whose aaah was high for SPLAT_LIMIT cycles survives. If aaah was high for SPLAT_LIMIT+1 or more cycles, the channel splats.
- Outputs are Moore decodes of the registered state. They are mutually exclusive: exactly one of walk_left, walk_right, aaah, digging, splat is 1 per channel.
- alive_cnt = N − popcount(splat). It is combinational from state, with no added latency.
- Unused state encodings recover to WL on the next edge.

## Timing
- Reset values, asserted immediately on areset regardless of clk:
  - state = WL and fall_cnt = 0 for all channels.
  - walk_left = all ones.
  - walk_right, aaah, digging, splat = 0.
  - alive_cnt = N.
- Latency: an input change affects outputs after the next rising edge, never combinationally.
- Reset mid-fall or in SPLAT: the channel returns to WL with its counter cleared. The first post-reset fall counts from 0.
- Simultaneous bump_left and bump_right in WL: only bump_left acts, so the channel goes to WR.
- dig and !ground together in a walk state: the fall wins.
- Saturation: with SPLAT_LIMIT = 2^CNT_W − 1, fall_cnt holds at max. The compare remains correct.

## Test plan
- Reset then idle (N=4, all ground=1, other inputs 0) → walk_left=4'b1111, alive_cnt=4 on every cycle.
- Channel 0: bump_left for 1 cycle → walk_right[0]=1 from the next edge. Then bump_right=1 and bump_left=1 for 1 cycle → walk_left[0]=1. Channels 1–3 unchanged.
- Channel 1 in WR: dig=1 for 1 cycle → digging[1]=1. Then ground[1]=0 → aaah[1]=1 on the next cycle. Then ground[1]=1 → walk_right[1]=1.
- Channel 2 with ground[2]=0 for exactly 20 aaah cycles, then ground=1 → walk_left[2]=1, splat[2]=0. Repeat with 21 aaah cycles → splat[2]=1, alive_cnt=3.
- Channel 2 in SPLAT: toggle all inputs for 50 cycles → splat[2] stays 1. Assert areset for 1 cycle → walk_left[2]=1, alive_cnt=4.
- CNT_W=5, SPLAT_LIMIT=31, fall for 40 cycles then land → fall_cnt saturates at 31, splat=1. The counter does not wrap to a survive.
